// File: rtl/pal_timing_pkg.sv
// PAL-D display timing defaults and counter types shared by the display controller.
package pal_timing_pkg;

   localparam int HW = 10;
   localparam int LW = 9;

   localparam int PAL_H_TOTAL  = 864;
   localparam int PAL_H_SYNC   = 64;
   localparam int PAL_H_ACT    = 144;
   localparam int PAL_LINES_F0 = 312;
   localparam int PAL_LINES_F1 = 313;
   localparam int PAL_V_SYNC   = 3;
   localparam int PAL_V_ACT    = 23;

   localparam logic [7:0] PAL_BLANK_LVL = 8'h10;

   typedef struct packed {
      logic [HW-1:0] h;
      logic [LW-1:0] l;
      logic          field;
   } pal_cnt_t;

endpackage

// File: rtl/pal_sync_counter.sv
// Pixel/line/field counters for the interlaced 312/313-line PAL raster.
module pal_sync_counter
   import pal_timing_pkg::*;
#(
   parameter int H_TOTAL = PAL_H_TOTAL
) (
   input  logic     clk,
   input  logic     rst,
   output pal_cnt_t cnt_nxt_o
);

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [LW-1:0] L0_LAST = LW'(PAL_LINES_F0 - 1);
   localparam logic [LW-1:0] L1_LAST = LW'(PAL_LINES_F1 - 1);

   pal_cnt_t cnt_q, cnt_d;
   logic     h_wrap, l_wrap;

   always_comb begin
      cnt_d   = cnt_q;
      h_wrap  = (cnt_q.h == H_LAST);
      l_wrap  = (cnt_q.l == (cnt_q.field ? L1_LAST : L0_LAST));
      cnt_d.h = h_wrap ? '0 : cnt_q.h + 1'b1;
      if (h_wrap) begin
         cnt_d.l = l_wrap ? '0 : cnt_q.l + 1'b1;
         if (l_wrap) cnt_d.field = ~cnt_q.field;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Next-state view lets the caller register decodes aligned with the count.
   assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/pal_display_timing.sv
// Display-side PAL-D controller: buffer fetch control, read-latency alignment and blanked video out.
module pal_display_timing
   import pal_timing_pkg::*;
#(
   parameter int         IW        = 640,
   parameter int         IH        = 512,
   parameter int         H_TOTAL   = PAL_H_TOTAL,
   parameter int         H_SYNC    = PAL_H_SYNC,
   parameter int         H_ACT     = PAL_H_ACT,
   parameter int         V_SYNC    = PAL_V_SYNC,
   parameter int         V_ACT     = PAL_V_ACT,
   parameter int         RD_LAT    = 3,
   parameter logic [7:0] BLANK_LVL = PAL_BLANK_LVL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pix_in,
   input  logic       pix_in_valid,
   output logic       fetch_req,
   output logic       vsync_dis,
   output logic       odd_even,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       csync_n,
   output logic       blank_n,
   output logic [7:0] video_out,
   output logic       align_err
);

   localparam logic [HW-1:0] FR_LO  = HW'(H_ACT - RD_LAT);
   localparam logic [HW-1:0] FR_HI  = HW'(H_ACT - RD_LAT + IW);
   localparam logic [HW-1:0] HS_END = HW'(H_SYNC);
   localparam logic [LW-1:0] VA_LO  = LW'(V_ACT);
   localparam logic [LW-1:0] VA_HI  = LW'(V_ACT + IH/2);
   localparam logic [LW-1:0] VS_END = LW'(V_SYNC);

   pal_cnt_t cnt_nxt;

   pal_sync_counter #(.H_TOTAL(H_TOTAL)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .cnt_nxt_o (cnt_nxt)
   );

   logic              fetch_d, hs_raw, vs_raw, exp_v;
   logic [RD_LAT:0]   vld_pipe_q;
   logic [RD_LAT+1:0] hs_pipe_q, vs_pipe_q;
   logic              vsync_dis_q, odd_even_q, blank_q, align_q;
   logic [7:0]        video_q;

   // Decoding the next count makes every registered strobe line up with the live count.
   always_comb begin
      fetch_d = (cnt_nxt.l >= VA_LO) && (cnt_nxt.l < VA_HI) &&
                (cnt_nxt.h >= FR_LO) && (cnt_nxt.h < FR_HI);
      hs_raw  = ~(cnt_nxt.h < HS_END);
      vs_raw  = ~(cnt_nxt.l < VS_END);
   end

   assign exp_v = vld_pipe_q[RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q  <= '0;
         // Stage 0 already reflects count 0 (inside both syncs); delayed stages idle high.
         hs_pipe_q   <= {{(RD_LAT+1){1'b1}}, 1'b0};
         vs_pipe_q   <= {{(RD_LAT+1){1'b1}}, 1'b0};
         vsync_dis_q <= 1'b1;
         odd_even_q  <= 1'b0;
         blank_q     <= 1'b0;
         video_q     <= BLANK_LVL;
         align_q     <= 1'b0;
      end else begin
         vld_pipe_q  <= {vld_pipe_q[RD_LAT-1:0], fetch_d};
         hs_pipe_q   <= {hs_pipe_q[RD_LAT:0], hs_raw};
         vs_pipe_q   <= {vs_pipe_q[RD_LAT:0], vs_raw};
         vsync_dis_q <= (cnt_nxt.l == '0);
         odd_even_q  <= cnt_nxt.field;
         blank_q     <= exp_v;
         video_q     <= exp_v ? pix_in : BLANK_LVL;
         align_q     <= align_q | (pix_in_valid != exp_v);
      end
   end

   assign fetch_req = vld_pipe_q[0];
   assign vsync_dis = vsync_dis_q;
   assign odd_even  = odd_even_q;
   assign hsync_n   = hs_pipe_q[RD_LAT+1];
   assign vsync_n   = vs_pipe_q[RD_LAT+1];
   assign csync_n   = hs_pipe_q[RD_LAT+1] & vs_pipe_q[RD_LAT+1];
   assign blank_n   = blank_q;
   assign video_out = video_q;
   assign align_err = align_q;

endmodule

// File: tb/tb_pal_display_timing.sv
// Directed bench: acts as the frame buffer, scoreboards returned pixels and tracks a raster model.
module tb_pal_display_timing;

   localparam int IW = 12, IH = 16, HT = 24, HS = 3, HA = 6, VS = 3, VA = 5, RL = 3;
   localparam int LF0 = 312, LF1 = 313;
   localparam logic [7:0] BLK = 8'h10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pix_in = '0;
   logic       pix_in_valid = 1'b0;
   logic       fetch_req, vsync_dis, odd_even, hsync_n, vsync_n, csync_n, blank_n, align_err;
   logic [7:0] video_out;

   pal_display_timing #(
      .IW(IW), .IH(IH), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT(HA),
      .V_SYNC(VS), .V_ACT(VA), .RD_LAT(RL), .BLANK_LVL(BLK)
   ) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_in_valid(pix_in_valid),
      .fetch_req(fetch_req), .vsync_dis(vsync_dis), .odd_even(odd_even),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n), .blank_n(blank_n),
      .video_out(video_out), .align_err(align_err)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   // raster model: index 0 is the current cycle, index k is k cycles ago
   int  mh, ml;
   bit  mf, m_err;
   bit  mfh [0:RL+1];
   bit  hh  [0:RL+1];
   bit  vh  [0:RL+1];

   // frame-buffer model and pixel scoreboard
   bit         bv [1:RL];
   logic [7:0] bd [1:RL];
   int         col;
   logic [7:0] sbq [$];

   int e_fetch, e_ctl, e_sync, e_cs, e_blk, e_err, e_vid;
   int f_fetch, f_vdis, f_vsl, flen;
   bit prev_oe, prev_fetch;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_fetch(input int h, input int l);
      return (l >= VA) && (l < VA + IH/2) && (h >= HA - RL) && (h < HA - RL + IW);
   endfunction

   task automatic m_set0();
      mfh[0] = m_fetch(mh, ml);
      hh[0]  = (mh >= HS);
      vh[0]  = (ml >= VS);
   endtask

   task automatic m_reset();
      mh = 0; ml = 0; mf = 1'b0; m_err = 1'b0;
      for (int i = 0; i <= RL+1; i++) begin mfh[i] = 1'b0; hh[i] = 1'b1; vh[i] = 1'b1; end
      m_set0();
      for (int i = 1; i <= RL; i++) bv[i] = 1'b0;
      col = 0; sbq.delete();
      f_fetch = 0; f_vdis = 0; f_vsl = 0; flen = 0;
      prev_oe = 1'b0; prev_fetch = 1'b0;
   endtask

   task automatic m_adv(input bit v);
      m_err = m_err | (v != mfh[RL]);
      for (int i = RL+1; i > 0; i--) begin mfh[i] = mfh[i-1]; hh[i] = hh[i-1]; vh[i] = vh[i-1]; end
      mh++;
      if (mh == HT) begin
         mh = 0; ml++;
         if (ml == (mf ? LF1 : LF0)) begin ml = 0; mf = ~mf; end
      end
      m_set0();
   endtask

   task automatic observe();
      logic [7:0] exp_px;
      if (fetch_req !== mfh[0]) e_fetch++;
      if (vsync_dis !== (ml == 0) || odd_even !== mf) e_ctl++;
      if (hsync_n !== hh[RL+1] || vsync_n !== vh[RL+1]) e_sync++;
      if (csync_n !== (hsync_n & vsync_n)) e_cs++;
      if (blank_n !== mfh[RL+1]) e_blk++;
      if (align_err !== m_err) e_err++;
      if (blank_n === 1'b1) begin
         if (sbq.size() == 0) e_vid++;
         else begin
            exp_px = sbq.pop_front();
            if (video_out !== exp_px) e_vid++;
         end
      end else if (video_out !== BLK) e_vid++;

      if (fetch_req === 1'b1 && !prev_fetch) chk("fetch_start_col", mh, HA - RL);
      prev_fetch = (fetch_req === 1'b1);
      if (odd_even !== prev_oe) begin
         chk("field_len", flen, prev_oe ? LF1*HT : LF0*HT);
         flen = 0;
      end
      flen++;
      prev_oe = (odd_even === 1'b1);
      if (fetch_req === 1'b1) f_fetch++;
      if (vsync_dis === 1'b1) f_vdis++;
      if (vsync_n === 1'b0)   f_vsl++;

      if (mh == HT-1) begin
         chk("line_fetch", e_fetch, 0);  chk("line_ctl", e_ctl, 0);
         chk("line_sync", e_sync, 0);    chk("line_csync", e_cs, 0);
         chk("line_blank", e_blk, 0);    chk("line_align", e_err, 0);
         chk("line_video", e_vid, 0);
         e_fetch = 0; e_ctl = 0; e_sync = 0; e_cs = 0; e_blk = 0; e_err = 0; e_vid = 0;
         if (ml == (mf ? LF1 : LF0) - 1) begin
            chk("field_fetch_cnt", f_fetch, IH/2*IW);
            chk("field_vdis_cnt", f_vdis, HT);
            chk("field_vsync_lo", f_vsl, VS*HT);
            f_fetch = 0; f_vdis = 0; f_vsl = 0;
         end
      end
   endtask

   // Drive inputs for the coming edge, advance the model, then check the next cycle.
   task automatic tick(input bit do_rst, input bit drop);
      logic       v;
      logic [7:0] d;
      v            = bv[RL] && !drop;
      rst          = do_rst;
      pix_in_valid = v;
      pix_in       = bv[RL] ? bd[RL] : 8'($urandom);
      if (bv[RL] && !do_rst) sbq.push_back(bd[RL]);
      if (fetch_req === 1'b1) begin d = 8'(col); col++; end
      else begin d = 8'h00; col = 0; end
      for (int i = RL; i > 1; i--) begin bv[i] = bv[i-1]; bd[i] = bd[i-1]; end
      bv[1] = (fetch_req === 1'b1);
      bd[1] = d;
      if (do_rst) m_reset();
      else        m_adv(v);
      @(negedge clk);
      observe();
   endtask

   task automatic run_to(input bit f, input int l, input int h);
      int n;
      n = 0;
      while (!(mf == f && ml == l && mh == h) && n < 20000) begin tick(1'b0, 1'b0); n++; end
      if (n >= 20000) begin
         total++; bad++;
         $error("FAIL run_to_timeout: got %0d/%0d want %0d/%0d", ml, mh, l, h);
      end
   endtask

   initial begin
      e_fetch = 0; e_ctl = 0; e_sync = 0; e_cs = 0; e_blk = 0; e_err = 0; e_vid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_fetch_req", 32'(fetch_req), 0);
      chk("rst_vsync_dis", 32'(vsync_dis), 1);
      chk("rst_odd_even",  32'(odd_even), 0);
      chk("rst_hsync_n",   32'(hsync_n), 1);
      chk("rst_vsync_n",   32'(vsync_n), 1);
      chk("rst_csync_n",   32'(csync_n), 1);
      chk("rst_blank_n",   32'(blank_n), 0);
      chk("rst_video_out", 32'(video_out), 32'(BLK));
      chk("rst_align_err", 32'(align_err), 0);
      m_reset();
      observe();

      // two clean frames
      repeat (2 * (LF0 + LF1) * HT) tick(1'b0, 1'b0);

      // single dropped valid in the middle of an active line
      run_to(1'b0, VA + 2, HA + 4);
      chk("err_before_drop", 32'(align_err), 0);
      tick(1'b0, 1'b1);
      chk("err_after_drop", 32'(align_err), 1);
      run_to(1'b1, 100, 5);
      tick(1'b0, 1'b0);
      run_to(1'b1, 100, 5);
      chk("err_sticky", 32'(align_err), 1);

      // one-clock reset at line 100 of field 1
      tick(1'b1, 1'b0);
      chk("mid_rst_odd_even",  32'(odd_even), 0);
      chk("mid_rst_vsync_dis", 32'(vsync_dis), 1);
      chk("mid_rst_fetch_req", 32'(fetch_req), 0);
      chk("mid_rst_align_err", 32'(align_err), 0);
      chk("mid_rst_blank_n",   32'(blank_n), 0);
      repeat ((LF0 + 2) * HT) tick(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pal_display_timing.md
Name: pal_display_timing

Overview:
- Display-side controller for the interlaced PAL-D frame buffer.
- Generates the read-side control the buffer consumes: fetch_req, vsync_dis and odd_even.
- Accepts the buffer's delayed pixel stream and emits blanked 8-bit video with hsync, vsync, csync and blank strobes to the video DAC/encoder.
- Sits between the frame buffer and the analogue video output stage, in the display clock domain.

Parameters:
- IW, 640, active pixels per line (must equal the buffer's IW).
- IH, 512, active lines per frame; IH/2 per field.
- H_TOTAL, 864, clocks per line (13.5 MHz PAL).
- H_SYNC, 64, hsync width in clocks.
- H_ACT, 144, first active pixel column; requires H_ACT+IW <= H_TOTAL.
- V_SYNC, 3, vsync lines at start of each field.
- V_ACT, 23, first active line within a field; requires V_ACT+IH/2 <= 312.
- RD_LAT, 3, clocks from fetch_req to the buffer's pixel valid.
- BLANK_LVL, 8'h10, video code driven outside the active window.

Ports:
- clk  in  1  display pixel clock.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  8  pixel data from the frame buffer.
- pix_in_valid  in  1  buffer data-valid; fetch_req delayed RD_LAT.
- fetch_req  out  1  request one pixel from the buffer this cycle.
- vsync_dis  out  1  field-start pulse; clears the buffer read counters.
- odd_even  out  1  field id: 0 = field 0, 1 = field 1.
- hsync_n  out  1  horizontal sync, active low.
- vsync_n  out  1  vertical sync, active low.
- csync_n  out  1  composite sync = hsync_n AND vsync_n, active low.
- blank_n  out  1  low outside the active window, aligned with video_out.
- video_out  out  8  output pixel.
- align_err  out  1  sticky error flag; pix_in_valid mismatched the expected window.

Behaviour:
- Reset (synchronous, active-high rst): all counters 0.
  - Outputs: fetch_req=0, vsync_dis=1, odd_even=0, hsync_n=1, vsync_n=1, csync_n=1, blank_n=0, video_out=BLANK_LVL, align_err=0.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps.
  - l_cnt (line in field) increments on h_cnt wrap.
  - Field 0 is 312 lines, field 1 is 313 lines. On l_cnt wrap, field toggles.
  - Frame total is 625 lines.
- odd_even = field. It changes only on the first clock of a new field and is stable for the whole field.
- vsync_dis is registered and high for all of line 0 of each field. It is therefore high before any fetch_req of that field.
- vsync_n is registered and low while l_cnt < V_SYNC.
- hsync_n is registered and low while h_cnt < H_SYNC, on every line.
- Active line: V_ACT <= l_cnt < V_ACT+IH/2, giving exactly IH/2 lines per field.
- fetch_req is high on active lines while H_ACT-RD_LAT <= h_cnt' < H_ACT-RD_LAT+IW. Here h_cnt' is the registered-output-aligned count.
  - Exactly IW requests per active line, contiguous.
  - Zero requests on all other lines.
- Expected window exp_v is fetch_req delayed through an RD_LAT-stage shift register.
- Output stage, 1 register, applied to the same cycle's pix_in:
  - video_out = pix_in if exp_v, else BLANK_LVL.
  - blank_n = exp_v.
- align_err is set on any cycle where pix_in_valid != exp_v, and stays set until rst.
- Sync strobes are delayed RD_LAT+1 so they align with video_out.
- Total latency from fetch_req to the corresponding video_out is RD_LAT+1 clocks.
- Reset mid-field: the next cycle restarts at field 0, line 0. vsync_dis=1 guarantees the buffer read address restarts.
- pix_in is ignored whenever exp_v=0.

Decomposition:
- Package pal_timing_pkg holds:
  - default timing constants: H_TOTAL, line counts 312/313, V_SYNC, V_ACT, H_ACT;
  - BLANK_LVL;
  - counter width constants: 10-bit h, 9-bit line.
- Sub-module pal_sync_counter contains the h_cnt/l_cnt/field counters and wrap logic, outputting counts plus field.
- Window decode, delay lines and output register live in the top level.

Test Plan:
- Release rst, run 2 frames with pix_in_valid = fetch_req delayed 3 → per field, 256 lines of exactly 640 fetch_req pulses each.
  - fetch_req starts at h_cnt=141. vsync_dis is high for 864 clocks at each field start.
  - align_err stays 0.
- Frame structure → field 0 spans 312×864 clocks and field 1 spans 313×864 clocks.
  - odd_even is 0 then 1 and toggles only at the field boundary.
  - vsync_n is low for 3×864 clocks per field.
- pix_in = column index mod 256 → video_out shows 0,1,2… starting at h_cnt=144 of the delayed timeline, with blank_n high for exactly 640 clocks.
  - Outside that window, video_out = 8'h10.
- Drop pix_in_valid for 1 cycle mid-line → align_err rises the next clock and remains 1 through the following frame.
- Assert rst for 1 clock at line 100 of field 1 → next clock: odd_even=0, vsync_dis=1, fetch_req=0.
  - The following field-0 timing is identical to the post-reset sequence.
- csync_n check → csync_n equals hsync_n AND vsync_n on every cycle across a full frame.
